// File: rtl/cnt_seq_ctrl_if.sv
// Bundle of the serial command port and the counter control strobes
// driven by cnt_seq_ctrl.
//
// Frame semantics: the host pulls cs_n low and presents one sdi bit per
// sclk rising edge, MSB first. A frame is exactly 4 + DATA_W bits:
// {opcode[3:0], payload}. The host returns cs_n high for at least one
// edge between frames. Fewer bits than a full frame, or extra bits
// after a full frame, count as framing errors. sdo returns an 8-bit
// status word starting one edge after the first bit of each frame.
interface cnt_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              cs_n;
  logic              sdi;
  logic              sdo;
  logic [DATA_W-1:0] load_data;
  logic              load;
  logic              en;
  logic              up;
  logic              oe;
  logic              busy;

  modport master (
    output cs_n, sdi,
    input  sdo, load_data, load, en, up, oe, busy
  );

  modport slave (
    input  cs_n, sdi,
    output sdo, load_data, load, en, up, oe, busy
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Serial-command sequencer for the loadable up/down counter.
// Receives fixed-length frames on cs_n/sdi, drives load/en/up/oe,
// runs timed count bursts and returns a sticky status word on sdo.
module cnt_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter bit OE_RST = 1'b0
) (
  input  logic           sclk,
  input  logic           rst_n,
  cnt_seq_ctrl_if.slave  bus,
  output logic           dbg_state
);

  localparam int FRAME_W = 4 + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_RUN_UP = 4'h2;
  localparam logic [3:0] OP_RUN_DN = 4'h3;
  localparam logic [3:0] OP_SET_OE = 4'h4;
  localparam logic [3:0] OP_STOP   = 4'h5;
  localparam logic [3:0] OP_CLR    = 4'h6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  run_cnt, run_cnt_nxt;

  logic [FRAME_W-2:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               frame_done;

  logic [FRAME_W-1:0] cmd;
  logic [3:0]         opcode;
  logic [DATA_W-1:0]  payload;
  logic               frame_last;

  logic               do_load, do_dir, do_stop, do_oe, do_clr;
  logic               drop_set, err_set;

  logic [DATA_W-1:0]  load_data_q;
  logic               load_q, en_q, up_q, oe_q, busy_q, sdo_q;
  logic               frame_err, drop;
  logic [6:0]         rd_sh;

  // The last bit is taken straight from sdi so the command decodes on
  // the same edge that captures it.
  assign frame_last = !bus.cs_n && !frame_done && (bit_cnt == CNT_W'(FRAME_W - 1));
  assign cmd        = {shreg, bus.sdi};
  assign opcode     = cmd[FRAME_W-1 -: 4];
  assign payload    = cmd[DATA_W-1:0];

  // Command decode; LOAD and RUN_* are refused while a burst is active.
  always_comb begin
    do_load  = 1'b0;
    do_dir   = 1'b0;
    do_stop  = 1'b0;
    do_oe    = 1'b0;
    do_clr   = 1'b0;
    drop_set = 1'b0;
    err_set  = (bus.cs_n && (bit_cnt != '0)) || (!bus.cs_n && frame_done);
    if (frame_last) begin
      case (opcode)
        4'h0:      ;
        OP_LOAD: begin
          if (state == IDLE) do_load = 1'b1;
          else               drop_set = 1'b1;
        end
        OP_RUN_UP, OP_RUN_DN: begin
          if (state == IDLE) do_dir = 1'b1;
          else               drop_set = 1'b1;
        end
        OP_SET_OE: do_oe   = 1'b1;
        OP_STOP:   do_stop = 1'b1;
        OP_CLR:    do_clr  = 1'b1;
        default:   err_set = 1'b1;
      endcase
    end
  end

  // Burst FSM next state: run_cnt holds the cycles left after this one.
  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    case (state)
      IDLE: begin
        if (do_dir && (payload != '0)) begin
          state_nxt   = RUN;
          run_cnt_nxt = payload - DATA_W'(1);
        end
      end
      RUN: begin
        if (do_stop || (run_cnt == '0)) state_nxt = IDLE;
        else                            run_cnt_nxt = run_cnt - DATA_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst FSM state register; en and busy follow the registered state.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_cnt <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_cnt_nxt;
      en_q    <= (state_nxt == RUN);
      busy_q  <= (state_nxt == RUN);
    end
  end

  // Frame receiver: shift bits, mark completion, lock out overrun bits.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (bus.cs_n) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (frame_done) begin
      bit_cnt    <= '0;
    end else if (frame_last) begin
      bit_cnt    <= '0;
      frame_done <= 1'b1;
    end else begin
      shreg      <= {shreg[FRAME_W-3:0], bus.sdi};
      bit_cnt    <= bit_cnt + CNT_W'(1);
    end
  end

  // Counter control outputs and sticky flags; a new error beats CLR_ERR.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_q <= '0;
      load_q      <= 1'b0;
      up_q        <= 1'b0;
      oe_q        <= OE_RST;
      frame_err   <= 1'b0;
      drop        <= 1'b0;
    end else begin
      load_q    <= do_load;
      frame_err <= err_set  | (frame_err & ~do_clr);
      drop      <= drop_set | (drop & ~do_clr);
      if (do_load) load_data_q <= payload;
      if (do_dir)  up_q        <= (opcode == OP_RUN_UP);
      if (do_oe)   oe_q        <= payload[0];
    end
  end

  // Status readback: snapshot on the first bit, then shift out MSB first.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_q <= 1'b0;
      rd_sh <= '0;
    end else if (bus.cs_n) begin
      sdo_q <= 1'b0;
      rd_sh <= '0;
    end else if ((bit_cnt == '0) && !frame_done) begin
      sdo_q <= busy_q;
      rd_sh <= {up_q, oe_q, frame_err, drop, 3'b000};
    end else begin
      sdo_q <= rd_sh[6];
      rd_sh <= {rd_sh[5:0], 1'b0};
    end
  end

  assign bus.load_data = load_data_q;
  assign bus.load      = load_q;
  assign bus.en        = en_q;
  assign bus.up        = up_q;
  assign bus.oe        = oe_q;
  assign bus.busy      = busy_q;
  assign bus.sdo       = sdo_q;
  assign dbg_state     = (state == RUN);

endmodule
